// File: rtl/fire_sched_pkg.sv
// Shared types and constants for the fire scheduler: FSM state encoding,
// fire-mode codes and the frame-tick counter width.
package fire_sched_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      GAP      = 2'd2,
      COOLDOWN = 2'd3
   } state_t;

   localparam logic [1:0] MODE_SINGLE = 2'd0;
   localparam logic [1:0] MODE_BURST  = 2'd1;
   localparam logic [1:0] MODE_AUTO   = 2'd2;

   // Wide enough for COOLDOWN_TICKS, BURST_GAP_TICKS and BURST_LEN up to 255.
   localparam int CNT_W = 8;

   // Mode code 3 is an alias of full-auto and is stored as MODE_AUTO.
   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_AUTO : m;
   endfunction

endpackage

// File: rtl/fire_scheduler_slot_priority_encoder.sv
// Combinational lowest-index-first search over the bullet engine idle flags.
module slot_priority_encoder #(
   parameter int NUM_SLOTS = 4
) (
   input  logic [NUM_SLOTS-1:0]         slot_free,
   output logic                         any_free,
   output logic [$clog2(NUM_SLOTS)-1:0] lowest
);

   localparam int SLOT_W = $clog2(NUM_SLOTS);

   assign any_free = |slot_free;

   // Walk downward so the last hit written is the lowest free index.
   always_comb begin
      lowest = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (slot_free[i]) lowest = SLOT_W'(i);
      end
   end

endmodule

// File: rtl/fire_scheduler.sv
// Turns fire requests into timed bullet launches (single / burst / auto).
// Optional magazine limit with reload input enabled by defining AMMO_LIMIT_EN.
module fire_scheduler
   import fire_sched_pkg::*;
#(
   parameter int NUM_SLOTS       = 4,
   parameter int COOLDOWN_TICKS  = 8,
   parameter int BURST_LEN       = 3,
   parameter int BURST_GAP_TICKS = 4,
   parameter int MAX_AMMO        = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_tick,
   input  logic                         fire,
   input  logic [1:0]                   fire_mode,
   input  logic [3:0]                   ss_angle_state,
   input  logic [NUM_SLOTS-1:0]         slot_free,
   input  logic                         launch_ack,
`ifdef AMMO_LIMIT_EN
   input  logic                         reload,
   output logic [3:0]                   ammo_count,
`endif
   output logic                         launch_valid,
   output logic [$clog2(NUM_SLOTS)-1:0] launch_slot,
   output logic [3:0]                   launch_angle,
   output logic [1:0]                   launch_mode,
   output logic                         busy
);

   localparam int SLOT_W = $clog2(NUM_SLOTS);

   // Handshake: launch_valid rises with slot/angle/mode and all three hold
   // until the edge where launch_valid & launch_ack; valid drops after it.
   state_t             state;
   logic               fire_q;
   logic [1:0]         mode_q;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   burst_left;
   logic               any_free;
   logic [SLOT_W-1:0]  lowest_idx;
   logic               fire_rise;
   logic               trig;
   logic               ack;
   logic               ammo_ok;
   logic               ammo_out;
   logic               last_shot;

   slot_priority_encoder #(.NUM_SLOTS(NUM_SLOTS)) u_prio (
      .slot_free (slot_free),
      .any_free  (any_free),
      .lowest    (lowest_idx)
   );

   assign fire_rise = fire & ~fire_q;
   assign ack       = launch_valid & launch_ack;
   assign busy      = (state != IDLE);

`ifdef AMMO_LIMIT_EN
   assign ammo_ok  = (ammo_count != 4'd0);
   // Magazine empties on this ack unless a reload lands on the same edge.
   assign ammo_out = (ammo_count == 4'd1) & ~reload;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             ammo_count <= 4'(MAX_AMMO);
      else if (reload)                     ammo_count <= 4'(MAX_AMMO);
      else if (ack && ammo_count != 4'd0)  ammo_count <= ammo_count - 4'd1;
   end
`else
   assign ammo_ok  = 1'b1;
   assign ammo_out = 1'b0;
`endif

   // Auto modes fire on the level, single and burst only on a new press.
   assign trig      = ammo_ok & (fire_mode[1] ? fire : fire_rise);
   assign last_shot = (burst_left == CNT_W'(1)) | ammo_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         fire_q       <= 1'b0;
         mode_q       <= MODE_SINGLE;
         cnt          <= '0;
         burst_left   <= '0;
         launch_valid <= 1'b0;
         launch_slot  <= '0;
         launch_angle <= '0;
         launch_mode  <= '0;
      end else begin
         fire_q <= fire;
         case (state)
            IDLE: begin
               if (trig) begin
                  mode_q     <= norm_mode(fire_mode);
                  burst_left <= (norm_mode(fire_mode) == MODE_BURST) ? CNT_W'(BURST_LEN) : CNT_W'(1);
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (!launch_valid) begin
                  if (any_free) begin
                     launch_valid <= 1'b1;
                     launch_slot  <= lowest_idx;
                     launch_angle <= ss_angle_state;
                     launch_mode  <= mode_q;
                  end
               end else if (launch_ack) begin
                  launch_valid <= 1'b0;
                  burst_left   <= burst_left - CNT_W'(1);
                  if (last_shot) begin
                     cnt   <= CNT_W'(COOLDOWN_TICKS);
                     state <= COOLDOWN;
                  end else begin
                     cnt   <= CNT_W'(BURST_GAP_TICKS);
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               if (frame_tick) begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) state <= ISSUE;
               end
            end
            COOLDOWN: begin
               // A zero cooldown leaves on the first cycle after the ack.
               if (cnt == '0) begin
                  state <= IDLE;
               end else if (frame_tick) begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fire_scheduler.md
Name: fire_scheduler

Overview:
- Sits between the button/mode input controller and the bullet engines.
- Turns the player fire request, fire mode and spaceship angle into timed bullet launches.
- Mode sequencing: single shot, 3-round burst or full-auto.
- Cooldown timing is counted in frame ticks.
- Allocates each launch to the lowest-index free bullet slot and holds it through a valid/ack handshake.

Parameters:
- NUM_SLOTS, 4, number of bullet engines (slots); must be ≥2.
- COOLDOWN_TICKS, 8, frame ticks between the end of a shot/burst and re-arm; 0 allowed.
- BURST_LEN, 3, bullets per burst in mode 1; must be ≥1.
- BURST_GAP_TICKS, 4, frame ticks between bullets inside a burst; must be ≥1.
- MAX_AMMO, 15, magazine size; used only with AMMO_LIMIT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- fire  in  1  fire request level, already synchronous to clk.
- fire_mode  in  2  0 = single, 1 = burst, 2 = auto, 3 = auto.
- ss_angle_state  in  4  current spaceship angle index.
- slot_free  in  NUM_SLOTS  bit i high = engine i idle.
- launch_ack  in  1  engine accepted the launch.
- launch_valid  out  1  launch request.
- launch_slot  out  $clog2(NUM_SLOTS)  target engine index.
- launch_angle  out  4  angle for this bullet.
- launch_mode  out  2  mode of the originating trigger.
- busy  out  1  high when state ≠ IDLE.
- (AMMO_LIMIT_EN only) reload  in  1; ammo_count  out  4.

Behaviour:
- Reset (async): state IDLE; all outputs 0; fire_q = 0; counters = 0.
- fire_rise = fire & ~fire_q, where fire_q is registered every cycle. Fire held through reset release counts as a rise.
- Triggers:
  - Modes 0/1 trigger on fire_rise.
  - Modes 2/3 trigger on the fire level.
  - Triggers arriving while busy are dropped, not queued.
- IDLE: on trigger:
  - latch mode (3 is stored as 2);
  - set burst_left = BURST_LEN for mode 1, else 1;
  - go to ISSUE.
- ISSUE:
  - If any slot_free bit is set, register launch_valid = 1 next cycle.
  - On that same edge, launch_slot takes the lowest free index and launch_angle samples ss_angle_state.
  - Slot, angle and mode stay stable while valid is high. Valid drops only on the cycle after the ack edge.
  - If no slot is free, stay in ISSUE with valid low.
  - A slot_free drop while valid is high is ignored; the request is held until ack.
- Handshake: an ack is the edge where launch_valid & launch_ack. launch_ack while valid is low is ignored.
  - On ack: burst_left decrements.
  - If the result is 0, load cnt = COOLDOWN_TICKS and go to COOLDOWN.
  - Otherwise load cnt = BURST_GAP_TICKS and go to GAP.
- GAP: cnt decrements on each frame_tick. The tick that makes cnt 0 moves to ISSUE, so the gap is exactly N ticks.
- COOLDOWN:
  - Same counting; at 0 go to IDLE.
  - If COOLDOWN_TICKS = 0, go to IDLE on the cycle after the ack.
- Auto mode: with fire still high in IDLE, retrigger the next cycle. One bullet per cooldown period.
- fire_mode and ss_angle_state changes mid-burst do not change the latched mode. Each burst bullet samples the angle at its own valid rise.
- Latency: trigger to launch_valid = 2 cycles when a slot is free.

Optional Feature:
- Macro: AMMO_LIMIT_EN.
- With the macro:
  - ammo_count resets to MAX_AMMO and decrements on each ack.
  - Triggers are blocked while ammo_count = 0.
  - If ammo reaches 0 mid-burst, the burst is truncated and the block goes to COOLDOWN.
  - A reload pulse sets ammo_count = MAX_AMMO in any state. Reload coincident with ack gives MAX_AMMO.
- Without the macro: no reload/ammo_count ports and unlimited shots.

Decomposition:
- Package fire_sched_pkg:
  - state encoding: IDLE, ISSUE, GAP, COOLDOWN;
  - mode constants: MODE_SINGLE = 0, MODE_BURST = 1, MODE_AUTO = 2;
  - tick counter width.
- One sub-module: slot_priority_encoder. It is combinational, parameterised by NUM_SLOTS, with outputs any_free and a lowest-index result.

Test Plan:
- Single, all slots free, ack 1 cycle after valid:
  - fire rise → launch_valid at cycle +2 with slot 0 and the current angle.
  - busy stays high for 8 frame ticks, then IDLE.
  - Holding fire gives no second shot.
- Burst with BURST_LEN = 3:
  - 3 launches, each 4 frame ticks apart.
  - Angle changed from 5 to 6 between shots 1 and 2 gives launch_angle 5, 6, 6.
  - launch_mode = 1 on all three.
- Slot allocation:
  - slot_free = 4'b1100 → launch_slot = 2.
  - slot_free = 0 → valid stays low until bit 3 rises, then slot = 3.
- Auto held for 40 ticks with COOLDOWN_TICKS = 8 → one launch per ~8 ticks; fire_mode = 3 behaves identically.
- Reset asserted while launch_valid is high → all outputs 0 immediately. After release with fire low → IDLE, no launch.
- With AMMO_LIMIT_EN and MAX_AMMO = 2:
  - a burst yields 2 launches, then COOLDOWN, then triggers are ignored;
  - a reload pulse restores ammo_count = 2 and the next fire launches.
